// File: rtl/codificador_comando_pkg.sv
// Shared constants for the push-button command encoder: command codes,
// encoder FSM encoding and the default debounce length.
package codificador_comando_pkg;

  localparam int unsigned DebounceCyclesDefault = 16;

  localparam logic [4:0] CMD_SOMA   = 5'd0;
  localparam logic [4:0] CMD_SUB    = 5'd1;
  localparam logic [4:0] CMD_MULT   = 5'd2;
  localparam logic [4:0] CMD_E      = 5'd3;
  localparam logic [4:0] CMD_OU     = 5'd4;
  localparam logic [4:0] CMD_NENHUM = 5'd31;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StIssue       = 2'd1,
    StWaitRelease = 2'd2
  } estado_e;

endpackage

// File: rtl/debounce_tecla.sv
// One key: 2-flop synchronizer, stability counter, debounced level and a
// registered one-cycle pulse on each debounced rising edge.
module debounce_tecla #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tecla_i,
  output logic nivel_o,
  output logic subida_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            nivel_q, nivel_d;
  logic            nivel_ant_q;
  logic            subida_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    nivel_d = nivel_q;
    cnt_d   = '0;
    if (sync2_q != nivel_q) begin
      if (cnt_q == CntMax) begin
        nivel_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      nivel_q     <= 1'b0;
      nivel_ant_q <= 1'b0;
      subida_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= tecla_i;
      sync2_q     <= sync1_q;
      nivel_q     <= nivel_d;
      nivel_ant_q <= nivel_q;
      subida_q    <= nivel_q & ~nivel_ant_q;
      cnt_q       <= cnt_d;
    end
  end

  assign nivel_o  = nivel_q;
  assign subida_o = subida_q;

endmodule

// File: rtl/codificador_comando.sv
// Push-button command encoder: debounces the keys and offers one command code
// per press over a valid/accept handshake, then waits for all keys released.
module codificador_comando
  import codificador_comando_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned N_KEYS          = 5,
  parameter int unsigned CMD_W           = 5
) (
  input  logic              clock_placa,
  input  logic              reset,
  input  logic [N_KEYS-1:0] teclas,
  output logic [CMD_W-1:0]  comando,
  output logic              comando_valido,
  input  logic              comando_aceito,
  output logic              ocupado,
  output logic              erro_multiplo,
  output logic [7:0]        descartes
);

  localparam logic [CMD_W-1:0] CmdNenhum = CMD_W'(CMD_NENHUM);

  logic [N_KEYS-1:0] nivel;
  logic [N_KEYS-1:0] eventos;
  logic              multiplos;

  estado_e          estado_q, estado_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [7:0]       descartes_q, descartes_d;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_tecla
    debounce_tecla #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clock_placa),
      .rst_ni  (reset),
      .tecla_i (teclas[k]),
      .nivel_o (nivel[k]),
      .subida_o(eventos[k])
    );
  end

  function automatic logic [CMD_W-1:0] menor_indice(input logic [N_KEYS-1:0] ev);
    logic [CMD_W-1:0] idx;
    idx = '0;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (ev[i]) idx = CMD_W'(i);
    end
    return idx;
  endfunction

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multiplos = |(eventos & (eventos - N_KEYS'(1)));

  always_ff @(posedge clock_placa or negedge reset) begin
    if (!reset) begin
      estado_q    <= StIdle;
      cmd_q       <= CmdNenhum;
      descartes_q <= 8'd0;
    end else begin
      estado_q    <= estado_d;
      cmd_q       <= cmd_d;
      descartes_q <= descartes_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    cmd_d       = cmd_q;
    descartes_d = descartes_q;
    case (estado_q)
      StIdle: begin
        if (|eventos) begin
          cmd_d    = menor_indice(eventos);
          estado_d = StIssue;
        end
      end
      StIssue: begin
        if (comando_aceito) estado_d = StWaitRelease;
      end
      StWaitRelease: begin
        if (nivel == '0) estado_d = StIdle;
      end
      default: estado_d = StIdle;
    endcase
    // Presses outside IDLE are lost; count cycles that lost any.
    if ((estado_q != StIdle) && (|eventos) && (descartes_q != 8'hFF)) begin
      descartes_d = descartes_q + 8'd1;
    end
  end

  always_comb begin
    comando_valido = 1'b0;
    comando        = CmdNenhum;
    ocupado        = (estado_q != StIdle);
    erro_multiplo  = 1'b0;
    case (estado_q)
      StIdle: erro_multiplo = multiplos;
      StIssue: begin
        comando_valido = 1'b1;
        comando        = cmd_q;
      end
      default: ;
    endcase
  end

  assign descartes = descartes_q;

endmodule

// File: tb/tb_codificador_comando.sv
// Directed bench for codificador_comando with DEBOUNCE_CYCLES=4: a vector
// table for clean presses plus hand-written multi-cycle sequences.
module tb_codificador_comando;

  localparam int unsigned Deb = 4;

  logic       clock_placa = 1'b0;
  logic       reset;
  logic [4:0] teclas;
  logic [4:0] comando;
  logic       comando_valido;
  logic       comando_aceito;
  logic       ocupado;
  logic       erro_multiplo;
  logic [7:0] descartes;

  int checks = 0;
  int errors = 0;

  always #5 clock_placa = ~clock_placa;

  codificador_comando #(
    .DEBOUNCE_CYCLES(Deb),
    .N_KEYS         (5),
    .CMD_W          (5)
  ) dut (
    .clock_placa   (clock_placa),
    .reset         (reset),
    .teclas        (teclas),
    .comando       (comando),
    .comando_valido(comando_valido),
    .comando_aceito(comando_aceito),
    .ocupado       (ocupado),
    .erro_multiplo (erro_multiplo),
    .descartes     (descartes)
  );

  typedef struct {
    logic [4:0] teclas;
    logic       aceito;
    int         reps;
    logic       valido;
    logic [4:0] cmd;
    logic       ocupado;
    logic       erro;
    logic [7:0] descartes;
  } vetor_t;

  localparam int NumVet = 13;
  vetor_t tabela [NumVet];

  task automatic tick();
    @(posedge clock_placa);
    #1;
  endtask

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  function automatic logic [15:0] saidas();
    return {comando_valido, comando, ocupado, erro_multiplo, descartes};
  endfunction

  task automatic wait_valid(input int limite, output int n);
    n = 0;
    while (!comando_valido && n < limite) begin
      tick();
      n++;
    end
    check("wait_valid", 32'(comando_valido), 32'd1);
  endtask

  task automatic wait_idle(input string nome);
    int n;
    n = 0;
    while (ocupado && n < 100) begin
      tick();
      n++;
    end
    check(nome, 32'(ocupado), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_valid;
    int n_ocup;
    int n_ruim;
    logic [4:0] cmd_visto;
    logic [11:0] padrao;
    logic [15:0] esperado;

    // Clean key 2 with accept tied high, then keys 1 and 3 together.
    tabela[0]  = '{5'h04, 1'b1, 7, 1'b0, 5'd31, 1'b0, 1'b0, 8'd0};
    tabela[1]  = '{5'h04, 1'b1, 1, 1'b1, 5'd2,  1'b1, 1'b0, 8'd0};
    tabela[2]  = '{5'h04, 1'b1, 2, 1'b0, 5'd31, 1'b1, 1'b0, 8'd0};
    tabela[3]  = '{5'h00, 1'b1, 6, 1'b0, 5'd31, 1'b1, 1'b0, 8'd0};
    tabela[4]  = '{5'h00, 1'b1, 1, 1'b0, 5'd31, 1'b0, 1'b0, 8'd0};
    tabela[5]  = '{5'h00, 1'b1, 3, 1'b0, 5'd31, 1'b0, 1'b0, 8'd0};
    tabela[6]  = '{5'h0A, 1'b1, 6, 1'b0, 5'd31, 1'b0, 1'b0, 8'd0};
    tabela[7]  = '{5'h0A, 1'b1, 1, 1'b0, 5'd31, 1'b0, 1'b1, 8'd0};
    tabela[8]  = '{5'h0A, 1'b1, 1, 1'b1, 5'd1,  1'b1, 1'b0, 8'd0};
    tabela[9]  = '{5'h0A, 1'b1, 1, 1'b0, 5'd31, 1'b1, 1'b0, 8'd0};
    tabela[10] = '{5'h00, 1'b1, 6, 1'b0, 5'd31, 1'b1, 1'b0, 8'd0};
    tabela[11] = '{5'h00, 1'b1, 1, 1'b0, 5'd31, 1'b0, 1'b0, 8'd0};
    tabela[12] = '{5'h00, 1'b1, 2, 1'b0, 5'd31, 1'b0, 1'b0, 8'd0};

    reset = 1'b0;
    teclas = 5'h00;
    comando_aceito = 1'b0;
    tick();
    tick();
    check("reset_state", 32'(saidas()), 32'({1'b0, 5'd31, 1'b0, 1'b0, 8'd0}));
    reset = 1'b1;
    tick();

    for (int r = 0; r < NumVet; r++) begin
      teclas = tabela[r].teclas;
      comando_aceito = tabela[r].aceito;
      esperado = {tabela[r].valido, tabela[r].cmd, tabela[r].ocupado, tabela[r].erro,
                  tabela[r].descartes};
      for (int k = 0; k < tabela[r].reps; k++) begin
        tick();
        check($sformatf("vet%0d.%0d", r, k), 32'(saidas()), 32'(esperado));
      end
    end

    // Key 0 bouncing (1, 2 and 3 cycle glitches) before settling high.
    padrao = 12'b100110011100;
    n_valid = 0;
    cmd_visto = 5'd31;
    for (int i = 0; i < 12; i++) begin
      teclas = {4'b0, padrao[11-i]};
      tick();
      if (comando_valido) begin n_valid++; cmd_visto = comando; end
    end
    teclas = 5'h01;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (comando_valido) begin n_valid++; cmd_visto = comando; end
    end
    check("bounce_transfers", 32'(n_valid), 32'd1);
    check("bounce_cmd", 32'(cmd_visto), 32'd0);
    teclas = 5'h00;
    wait_idle("bounce_idle");

    // Glitches only: nothing may be issued.
    n_valid = 0;
    n_ocup = 0;
    for (int i = 0; i < 12; i++) begin
      teclas = {4'b0, padrao[11-i]};
      tick();
      n_valid += int'(comando_valido);
      n_ocup += int'(ocupado);
    end
    teclas = 5'h00;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_valid += int'(comando_valido);
      n_ocup += int'(ocupado);
    end
    check("glitch_no_valid", 32'(n_valid), 32'd0);
    check("glitch_no_busy", 32'(n_ocup), 32'd0);

    // Back-pressure: key 4 held in ISSUE for 50 cycles without accept.
    comando_aceito = 1'b0;
    teclas = 5'h10;
    wait_valid(30, n);
    // Edges 0..DEBOUNCE_CYCLES+3 inclusive.
    check("latency_key4", 32'(n), 32'(Deb + 4));
    n_ruim = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (comando_valido !== 1'b1 || comando !== 5'd4) n_ruim++;
    end
    check("hold_stable", 32'(n_ruim), 32'd0);
    comando_aceito = 1'b1;
    tick();
    check("after_accept", 32'({comando_valido, comando, ocupado}), 32'({1'b0, 5'd31, 1'b1}));
    teclas = 5'h00;
    wait_idle("hold_idle");

    // Key 2 held in WAIT_RELEASE while key 4 is pressed 300 times.
    teclas = 5'h04;
    wait_valid(30, n);
    check("hold2_cmd", 32'(comando), 32'd2);
    tick();
    check("hold2_wait", 32'({comando_valido, ocupado}), 32'({1'b0, 1'b1}));
    n_valid = 0;
    for (int p = 0; p < 300; p++) begin
      teclas = 5'h14;
      for (int i = 0; i < 8; i++) begin tick(); n_valid += int'(comando_valido); end
      teclas = 5'h04;
      for (int i = 0; i < 8; i++) begin tick(); n_valid += int'(comando_valido); end
      if (p == 2) check("drops_3", 32'(descartes), 32'd3);
    end
    check("drops_sat", 32'(descartes), 32'd255);
    check("drops_no_valid", 32'(n_valid), 32'd0);
    teclas = 5'h00;
    wait_idle("drops_idle");
    check("drops_kept", 32'(descartes), 32'd255);

    // Reset asserted in ISSUE drops valid without waiting for a clock edge.
    comando_aceito = 1'b0;
    teclas = 5'h02;
    wait_valid(30, n);
    check("pre_reset_cmd", 32'(comando), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 32'(saidas()), 32'({1'b0, 5'd31, 1'b0, 1'b0, 8'd0}));
    teclas = 5'h00;
    tick();
    tick();
    reset = 1'b1;
    tick();
    comando_aceito = 1'b1;
    teclas = 5'h08;
    wait_valid(30, n);
    check("post_reset_latency", 32'(n), 32'(Deb + 4));
    check("post_reset_cmd", 32'(comando), 32'd3);
    tick();
    check("post_reset_xfer", 32'({comando_valido, ocupado, descartes}),
          32'({1'b0, 1'b1, 8'd0}));
    teclas = 5'h00;
    wait_idle("post_reset_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
